data_recv: RTL and testbench

DATA_RECV -- requirements
Module: data_recv

---
 rtl/data_recv_pkg.sv | 20 ++
 rtl/data_recv_sat_counter.sv | 28 ++
 rtl/data_recv.sv | 161 ++++++++++++++++
 tb/tb_data_recv.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/data_recv_pkg.sv
// Shared definitions for the incrementing-pattern frame checker.
//   state_t    : receive FSM encoding (IDLE, FRAME, RESYNC)
//   ERR_*      : error codes reported in last_err_code; the TX generator's
//                debug logic decodes the same values.
package data_recv_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FRAME  = 2'd1,
    ST_RESYNC = 2'd2
  } state_t;

  localparam logic [2:0] ERR_NONE  = 3'd0;
  localparam logic [2:0] ERR_DATA  = 3'd1;
  localparam logic [2:0] ERR_KEEP  = 3'd2;
  localparam logic [2:0] ERR_SHORT = 3'd3;
  localparam logic [2:0] ERR_LONG  = 3'd4;
  localparam logic [2:0] ERR_USER  = 3'd5;

endpackage

// File: rtl/data_recv_sat_counter.sv
// Saturating statistics counter.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : synchronous zero, wins over inc
//   inc        : add one unless already all ones
//   count      : current value (never wraps)
module sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + ONE;
    end
  end

endmodule

// File: rtl/data_recv.sv
// Receive-side checker for the 512-bit incrementing-pattern test frames
// looped back through the CMAC. Beat k of a frame must carry data == k,
// full tkeep and tlast only on beat FRAME_BEATS.
//
// Handshake: AXI-Stream without tready; every cycle with axis_tvalid high is
// one accepted beat, and all checker state holds on cycles with tvalid low.
//
// Ports:
//   axis_aclk, axis_aresetn : clock, asynchronous active-low reset
//   clear_stats             : pulse, zeroes counters/err_flag/last_err_code
//   axis_t*                 : RX beat (tuser only meaningful with tlast)
//   frame_cnt/good_cnt/err_cnt : saturating frame statistics
//   err_flag                : sticky, set by any bad frame
//   last_err_code           : first error code of the most recent bad frame
//   rx_busy                 : frame in progress (FRAME or RESYNC)
//   fsm_state               : FSM state, exposed for debug
module data_recv
  import data_recv_pkg::*;
#(
  parameter int FRAME_BEATS = 11,
  parameter int CNT_W       = 32
) (
  input  logic             axis_aclk,
  input  logic             axis_aresetn,
  input  logic             clear_stats,
  input  logic             axis_tvalid,
  input  logic [511:0]     axis_tdata,
  input  logic [63:0]      axis_tkeep,
  input  logic             axis_tlast,
  input  logic             axis_tuser,
  output logic [CNT_W-1:0] frame_cnt,
  output logic [CNT_W-1:0] good_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic             err_flag,
  output logic [2:0]       last_err_code,
  output logic             rx_busy,
  output state_t           fsm_state
);

  localparam logic [7:0] LAST_IDX = 8'(FRAME_BEATS);

  state_t     state;
  logic [7:0] k;          // beats accepted so far in the current frame
  logic [2:0] frame_err;  // first error seen in the current frame
  logic [7:0] exp_idx;
  logic       at_end;
  logic [2:0] beat_code;
  logic [2:0] first_code;
  logic       complete;
  logic [2:0] done_code;
  logic       done_bad;

  // k is 0 in IDLE, so the incoming beat is always beat k+1.
  assign exp_idx = k + 8'd1;
  assign at_end  = (exp_idx == LAST_IDX);

  // Same-beat priority: length errors, then data, then tkeep, then tuser.
  always_comb begin
    beat_code = ERR_NONE;
    if (axis_tlast && !at_end) begin
      beat_code = ERR_SHORT;
    end else if (!axis_tlast && at_end) begin
      beat_code = ERR_LONG;
    end else if (axis_tdata != 512'(exp_idx)) begin
      beat_code = ERR_DATA;
    end else if (axis_tkeep != '1) begin
      beat_code = ERR_KEEP;
    end else if (axis_tlast && axis_tuser) begin
      beat_code = ERR_USER;
    end
  end

  assign first_code = (frame_err != ERR_NONE) ? frame_err : beat_code;

  // In RESYNC beats are discarded unchecked; the recorded error stands.
  always_comb begin
    complete  = 1'b0;
    done_code = ERR_NONE;
    if (axis_tvalid && axis_tlast) begin
      complete  = 1'b1;
      done_code = (state == ST_RESYNC) ? frame_err : first_code;
    end
  end

  assign done_bad = (done_code != ERR_NONE);

  always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
    if (!axis_aresetn) begin
      state     <= ST_IDLE;
      k         <= 8'd0;
      frame_err <= ERR_NONE;
    end else if (axis_tvalid) begin
      case (state)
        ST_IDLE, ST_FRAME: begin
          if (axis_tlast) begin
            state     <= ST_IDLE;
            k         <= 8'd0;
            frame_err <= ERR_NONE;
          end else begin
            state     <= at_end ? ST_RESYNC : ST_FRAME;
            k         <= exp_idx;
            frame_err <= first_code;
          end
        end
        ST_RESYNC: begin
          if (axis_tlast) begin
            state     <= ST_IDLE;
            k         <= 8'd0;
            frame_err <= ERR_NONE;
          end
        end
        default: begin
          state     <= ST_IDLE;
          k         <= 8'd0;
          frame_err <= ERR_NONE;
        end
      endcase
    end
  end

  always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
    if (!axis_aresetn) begin
      err_flag      <= 1'b0;
      last_err_code <= ERR_NONE;
    end else if (clear_stats) begin
      err_flag      <= 1'b0;
      last_err_code <= ERR_NONE;
    end else if (complete && done_bad) begin
      err_flag      <= 1'b1;
      last_err_code <= done_code;
    end
  end

  assign rx_busy   = (state != ST_IDLE);
  assign fsm_state = state;

  sat_counter #(.CNT_W(CNT_W)) u_frame_cnt (
    .clk   (axis_aclk),
    .rst_n (axis_aresetn),
    .clr   (clear_stats),
    .inc   (complete),
    .count (frame_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_good_cnt (
    .clk   (axis_aclk),
    .rst_n (axis_aresetn),
    .clr   (clear_stats),
    .inc   (complete && !done_bad),
    .count (good_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_err_cnt (
    .clk   (axis_aclk),
    .rst_n (axis_aresetn),
    .clr   (clear_stats),
    .inc   (complete && done_bad),
    .count (err_cnt)
  );

endmodule

// File: tb/tb_data_recv.sv
module tb_data_recv;
  import data_recv_pkg::*;

  localparam int FB    = 11;
  localparam int CNT_W = 32;
  localparam longint unsigned MAXV = 64'hFFFF_FFFF;

  logic             clk;
  logic             rst_n;
  logic             clear_stats;
  logic             tvalid;
  logic [511:0]     tdata;
  logic [63:0]      tkeep;
  logic             tlast;
  logic             tuser;
  logic [CNT_W-1:0] frame_cnt;
  logic [CNT_W-1:0] good_cnt;
  logic [CNT_W-1:0] err_cnt;
  logic             err_flag;
  logic [2:0]       last_err_code;
  logic             rx_busy;
  state_t           fsm_state;

  data_recv #(.FRAME_BEATS(FB), .CNT_W(CNT_W)) dut (
    .axis_aclk     (clk),
    .axis_aresetn  (rst_n),
    .clear_stats   (clear_stats),
    .axis_tvalid   (tvalid),
    .axis_tdata    (tdata),
    .axis_tkeep    (tkeep),
    .axis_tlast    (tlast),
    .axis_tuser    (tuser),
    .frame_cnt     (frame_cnt),
    .good_cnt      (good_cnt),
    .err_cnt       (err_cnt),
    .err_flag      (err_flag),
    .last_err_code (last_err_code),
    .rx_busy       (rx_busy),
    .fsm_state     (fsm_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [511:0] data;
    logic [63:0]  keep;
    logic         last;
    logic         user;
    int           gap;
  } beat_t;

  beat_t frm[$];
  logic [2:0] exp_q[$];

  longint unsigned m_frame, m_good, m_err;
  logic            m_flag;
  logic [2:0]      m_code;

  task automatic model_zero();
    m_frame = 0; m_good = 0; m_err = 0; m_flag = 1'b0; m_code = 3'd0;
  endtask

  function automatic longint unsigned sat_inc(input longint unsigned v);
    return (v < MAXV) ? v + 1 : v;
  endfunction

  // Frame-level classification: first error in beat order; beats past
  // FRAME_BEATS belong to the resync tail and are not examined.
  function automatic logic [2:0] classify();
    logic [2:0] code;
    logic [2:0] c;
    code = 3'd0;
    for (int j = 0; j < frm.size(); j++) begin
      int idx;
      idx = j + 1;
      c = 3'd0;
      if (idx <= FB) begin
        if (frm[j].last && idx < FB)              c = 3'd3;
        else if (!frm[j].last && idx == FB)       c = 3'd4;
        else if (frm[j].data != 512'(idx))        c = 3'd1;
        else if (frm[j].keep != {64{1'b1}})       c = 3'd2;
        else if (frm[j].last && frm[j].user)      c = 3'd5;
        if (code == 3'd0) code = c;
      end
    end
    return code;
  endfunction

  task automatic model_frame(input int clr_at);
    logic [2:0] code;
    exp_q.push_back(classify());
    code = exp_q.pop_front();
    if (clr_at > 0 && clr_at < frm.size()) model_zero();
    if (clr_at == frm.size()) begin
      model_zero();
    end else begin
      m_frame = sat_inc(m_frame);
      if (code == 3'd0) m_good = sat_inc(m_good);
      else begin
        m_err  = sat_inc(m_err);
        m_flag = 1'b1;
        m_code = code;
      end
    end
  endtask

  task automatic check_stats(input string tag);
    check({tag, ".frame_cnt"}, 64'(frame_cnt), m_frame);
    check({tag, ".good_cnt"},  64'(good_cnt),  m_good);
    check({tag, ".err_cnt"},   64'(err_cnt),   m_err);
    check({tag, ".err_flag"},  64'(err_flag),  64'(m_flag));
    check({tag, ".code"},      64'(last_err_code), 64'(m_code));
    check({tag, ".rx_busy"},   64'(rx_busy),   64'd0);
  endtask

  // ---------------- drivers ----------------
  task automatic drive_idle();
    tvalid = 1'b0; tdata = '0; tkeep = '0; tlast = 1'b0; tuser = 1'b0;
    clear_stats = 1'b0;
  endtask

  task automatic build_good(input int len);
    beat_t b;
    frm.delete();
    for (int i = 1; i <= len; i++) begin
      b.data = 512'(i);
      b.keep = {64{1'b1}};
      b.last = (i == len);
      b.user = 1'b0;
      b.gap  = 0;
      frm.push_back(b);
    end
  endtask

  // clr_at: 1-based beat on which clear_stats is pulsed, 0 for none.
  task automatic send_frame(input string tag, input int clr_at);
    for (int j = 0; j < frm.size(); j++) begin
      @(negedge clk);
      if (j > 0) check({tag, ".busy"}, 64'(rx_busy), 64'd1);
      tvalid = 1'b1;
      tdata  = frm[j].data;
      tkeep  = frm[j].keep;
      tlast  = frm[j].last;
      tuser  = frm[j].user;
      clear_stats = (clr_at == j + 1);
      for (int g = 0; g < frm[j].gap; g++) begin
        @(negedge clk);
        drive_idle();
      end
    end
    @(negedge clk);
    drive_idle();
    model_frame(clr_at);
    check_stats(tag);
  endtask

  task automatic do_reset();
    @(negedge clk);
    drive_idle();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_zero();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0;
    drive_idle();
    model_zero();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_stats("reset");

    // Three back-to-back good frames
    for (int f = 0; f < 3; f++) begin
      build_good(FB);
      send_frame("good3", 0);
    end

    // Data error on beat 5, then a good frame keeps err_flag
    build_good(FB);
    frm[4].data = 512'h99;
    send_frame("data_err", 0);
    build_good(FB);
    send_frame("good_after_data", 0);

    // Upper-bit data corruption exercises the full-width compare
    build_good(FB);
    frm[2].data[500] = 1'b1;
    send_frame("data_hi", 0);

    // Short frame then immediate resync on beat 1
    build_good(7);
    send_frame("short", 0);
    build_good(FB);
    send_frame("good_after_short", 0);

    // Long frame goes through RESYNC, counted once
    build_good(13);
    send_frame("long", 0);
    build_good(FB);
    send_frame("good_after_long", 0);

    // Idle gaps inside a frame
    build_good(FB);
    frm[1].gap = 1; frm[4].gap = 3; frm[8].gap = 2;
    send_frame("gaps", 0);

    // tuser on the tlast beat
    build_good(FB);
    frm[FB-1].user = 1'b1;
    send_frame("tuser", 0);

    // tkeep error, and same-beat priorities
    build_good(FB);
    frm[3].keep[17] = 1'b0;
    send_frame("keep", 0);
    build_good(FB);
    frm[6].keep = '0; frm[6].data = 512'h5;
    send_frame("data_over_keep", 0);
    build_good(4);
    frm[3].data = 512'h77;
    send_frame("short_over_data", 0);
    build_good(FB);
    frm[FB-1].user = 1'b1; frm[FB-1].data = 512'h3;
    send_frame("data_over_user", 0);
    build_good(1);
    send_frame("single_beat", 0);

    // clear_stats idle, mid-frame (FSM unaffected) and on the tlast beat
    @(negedge clk);
    clear_stats = 1'b1;
    @(negedge clk);
    clear_stats = 1'b0;
    model_zero();
    check_stats("clear_idle");
    build_good(FB);
    send_frame("clear_mid", 4);
    build_good(FB);
    frm[2].data = 512'h0;
    send_frame("bad_pre_clr", 0);
    build_good(FB);
    send_frame("clear_last", FB);

    // Reset mid-frame discards the partial frame
    build_good(FB);
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      tvalid = 1'b1; tdata = frm[j].data; tkeep = frm[j].keep;
      tlast = 1'b0; tuser = 1'b0;
    end
    do_reset();
    @(negedge clk);
    check_stats("mid_reset");
    build_good(FB);
    send_frame("after_reset", 0);

    // Randomized frames
    for (int f = 0; f < 40; f++) begin
      int len;
      int clr_at;
      len = ($urandom_range(0, 9) < 6) ? FB : $urandom_range(1, 14);
      build_good(len);
      if ($urandom_range(0, 3) == 0) frm[$urandom_range(0, len-1)].data[$urandom_range(0, 511)] ^= 1'b1;
      if ($urandom_range(0, 5) == 0) frm[$urandom_range(0, len-1)].keep[$urandom_range(0, 63)] = 1'b0;
      if ($urandom_range(0, 5) == 0) frm[len-1].user = 1'b1;
      for (int j = 0; j < len - 1; j++)
        if ($urandom_range(0, 4) == 0) frm[j].gap = $urandom_range(1, 3);
      clr_at = ($urandom_range(0, 9) == 0) ? $urandom_range(1, len) : 0;
      send_frame("rand", clr_at);
    end

    // Saturation: preload counters near all ones
    @(negedge clk);
    force dut.u_frame_cnt.count = 32'hFFFF_FFFE;
    force dut.u_good_cnt.count  = 32'hFFFF_FFFE;
    force dut.u_err_cnt.count   = 32'hFFFF_FFFF;
    #1;
    release dut.u_frame_cnt.count;
    release dut.u_good_cnt.count;
    release dut.u_err_cnt.count;
    m_frame = 64'hFFFF_FFFE; m_good = 64'hFFFF_FFFE; m_err = 64'hFFFF_FFFF;
    build_good(FB);
    send_frame("sat1", 0);
    build_good(FB);
    send_frame("sat2", 0);
    build_good(5);
    send_frame("sat_err", 0);
    build_good(FB);
    send_frame("sat_clear_last", FB);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
